// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: CHUNK bits per stage, carry registered between stages, valid/ready on both sides.
// Optional macro PIPE_ADDER_SUB_EN adds a per-transaction 'sub' input (a - b).
module pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned CW     = CHUNK + 1;

    logic              init_q, init_d;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;

    logic              adv_c;
    logic [WIDTH-1:0]  b_in_c;
    logic              cin_in_c;
    logic [STAGES-1:0] pv_c, pc_c;
    logic [WIDTH-1:0]  pa_c [STAGES];
    logic [WIDTH-1:0]  pb_c [STAGES];
    logic [WIDTH-1:0]  ps_c [STAGES];
    logic [CHUNK:0]    res_c [STAGES];

    // Subtraction is folded in at capture: invert b and force the carry-in.
    always_comb begin
        b_in_c   = b;
        cin_in_c = cin;
`ifdef PIPE_ADDER_SUB_EN
        if (sub) begin
            b_in_c   = ~b;
            cin_in_c = 1'b1;
        end
`endif
    end

    always_comb begin
        adv_c  = !vld_q[STAGES-1] || out_ready;
        init_d = 1'b1;
        vld_d  = vld_q;
        cry_d  = cry_q;
        ovf_d  = ovf_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        sum_d  = sum_q;

        // Predecessor of stage 0 is the input port; of stage k, register k-1.
        pv_c[0] = in_valid && init_q;
        pc_c[0] = cin_in_c;
        pa_c[0] = a;
        pb_c[0] = b_in_c;
        ps_c[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            pv_c[k] = vld_q[k-1];
            pc_c[k] = cry_q[k-1];
            pa_c[k] = opa_q[k-1];
            pb_c[k] = opb_q[k-1];
            ps_c[k] = sum_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            res_c[k] = {1'b0, pa_c[k][k*CHUNK +: CHUNK]} + {1'b0, pb_c[k][k*CHUNK +: CHUNK]}
                     + CW'(pc_c[k]);
            if (adv_c) begin
                vld_d[k] = pv_c[k];
                if (pv_c[k]) begin
                    opa_d[k]                   = pa_c[k];
                    opb_d[k]                   = pb_c[k];
                    cry_d[k]                   = res_c[k][CHUNK];
                    sum_d[k]                   = ps_c[k];
                    sum_d[k][k*CHUNK +: CHUNK] = res_c[k][CHUNK-1:0];
                end
            end
        end

        // Carry into the MSB recovered from the MSB sum bit of the final slice.
        if (adv_c && pv_c[STAGES-1]) begin
            ovf_d = (pa_c[STAGES-1][WIDTH-1] ^ pb_c[STAGES-1][WIDTH-1] ^ res_c[STAGES-1][CHUNK-1])
                  ^ res_c[STAGES-1][CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            vld_q  <= '0;
            cry_q  <= '0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            init_q <= init_d;
            vld_q  <= vld_d;
            cry_q  <= cry_d;
            ovf_q  <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = init_q && adv_c;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = cry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, CHUNK=4): vector table, stream, backpressure, reset, optional sub.
module tb_pipe_adder;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef PIPE_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif

    pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t         vecs [6];
    logic [17:0]  exp_q [$];
    logic [17:0]  got_log [$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_acc = 0;
    int           n_ret = 0;

    // Reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                          input logic ic, input logic is);
        logic [16:0]  r;
        logic [W-1:0] be;
        logic         ce;
        logic         ov;
        be = is ? ~ib : ib;
        ce = is ? 1'b1 : ic;
        r  = {1'b0, ia} + {1'b0, be} + 17'(ce);
        ov = (ia[W-1] == be[W-1]) && (r[W-1] != ia[W-1]);
        return {ov, r[16], r[W-1:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    // One cycle: drive at negedge, then score both handshakes just before the next edge.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic ordy, input logic is);
        logic [17:0] o;
        logic        sb;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        out_ready = ordy;
        sb        = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
        sub = is;
        sb  = is;
`endif
        #1;
        if (out_valid && out_ready) begin
            o = {ovf, cout, sum};
            n_ret++;
            got_log.push_back(o);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_result: got %0h expected none", o);
            end else begin
                check("result", 32'(o), 32'(exp_q.pop_front()));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(ia, ib, ic, sb));
            n_acc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        int ret0;
        int lat;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        step(0, '0, '0, 0, 1, 0);
        check("ready_after_rst", 32'(in_ready), 1);

        // Directed vectors, one at a time, with latency measurement
        foreach (vecs[i]) begin
            acc0 = n_acc;
            ret0 = n_ret;
            got_log.delete();
            step(1, vecs[i].a, vecs[i].b, vecs[i].cin, 1, 0);
            check("vec_accepted", 32'(n_acc - acc0), 1);
            lat = 0;
            for (int n = 1; n <= 10 && n_ret == ret0; n++) begin
                step(0, '0, '0, 0, 1, 0);
                if (n_ret != ret0) lat = n;
            end
            check("vec_latency", 32'(lat), S);
            if (got_log.size() == 1) begin
                check("vec_sum", 32'(got_log[0][15:0]), 32'(vecs[i].s));
                check("vec_cout", 32'(got_log[0][16]), 32'(vecs[i].co));
                check("vec_ovf", 32'(got_log[0][17]), 32'(vecs[i].ov));
            end else begin
                check("vec_result_count", 32'(got_log.size()), 1);
            end
        end

        // Back-to-back stream of 20, out_ready held high
        acc0 = n_acc;
        ret0 = n_ret;
        for (int i = 0; i < 20; i++)
            step(1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1, 0);
        repeat (S) step(0, '0, '0, 0, 1, 0);
        check("stream_accepted", 32'(n_acc - acc0), 20);
        check("stream_retired", 32'(n_ret - ret0), 20);
        check("stream_drained", 32'(exp_q.size()), 0);

        // Backpressure: fill, stall 6 cycles with new inputs offered, release
        acc0 = n_acc;
        ret0 = n_ret;
        for (int i = 0; i < S; i++) begin
            step(1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 0, 0);
            check("fill_in_ready", 32'(in_ready), 1);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 0, 0);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            if (exp_q.size() > 0) check("stall_hold", 32'({ovf, cout, sum}), 32'(exp_q[0]));
        end
        repeat (8) step(0, '0, '0, 0, 1, 0);
        check("bp_accepted", 32'(n_acc - acc0), S);
        check("bp_retired", 32'(n_ret - ret0), S);
        check("bp_drained", 32'(exp_q.size()), 0);

        // Reset mid-flight with a full pipe and a valid result showing
        for (int i = 0; i < S; i++) step(1, 16'hFFFF, 16'hFFFF, 1, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_sum", 32'(sum), 0);
        check("midrst_cout", 32'(cout), 0);
        check("midrst_ovf", 32'(ovf), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ret0 = n_ret;
        for (int i = 0; i < 8; i++) begin
            step(0, '0, '0, 0, 1, 0);
            check("post_rst_idle", 32'(out_valid), 0);
        end
        step(1, 16'h1111, 16'h2222, 0, 1, 0);
        for (int n = 0; n < 10 && n_ret == ret0; n++) step(0, '0, '0, 0, 1, 0);
        check("post_rst_result", 32'(n_ret - ret0), 1);

`ifdef PIPE_ADDER_SUB_EN
        // Mixed sub/add stream at full rate
        got_log.delete();
        ret0 = n_ret;
        step(1, 16'h0005, 16'h0007, 1, 1, 1);
        step(1, 16'h0007, 16'h0005, 0, 1, 1);
        step(1, 16'h0003, 16'h0004, 0, 1, 0);
        for (int n = 0; n < 10 && n_ret - ret0 < 3; n++) step(0, '0, '0, 0, 1, 0);
        check("sub_count", 32'(got_log.size()), 3);
        if (got_log.size() == 3) begin
            check("sub_5m7", 32'(got_log[0]), 32'({1'b0, 1'b0, 16'hFFFE}));
            check("sub_7m5", 32'(got_log[1]), 32'({1'b0, 1'b1, 16'h0002}));
            check("add_after_sub", 32'(got_log[2]), 32'({1'b0, 1'b0, 16'h0007}));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
